// File: rtl/toy_rename_freelist.sv
// Physical-register free list: compacted multi-slot allocate, in-order release at
// commit, and rollback of speculative allocations to the committed head on cancel.
module toy_rename_freelist #(
  parameter int unsigned INST_DECODE_NUM  = 4,
  parameter int unsigned COMMIT_NUM       = 4,
  parameter int unsigned PHY_REG_NUM      = 64,
  parameter int unsigned ARCH_ENTRY_NUM   = 32,
  parameter int unsigned PHY_REG_ID_WIDTH = 6,
  parameter int unsigned FL_DEPTH         = PHY_REG_NUM - ARCH_ENTRY_NUM
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [INST_DECODE_NUM-1:0]                   v_alloc_req,
  output logic                                         alloc_ready,
  output logic [INST_DECODE_NUM*PHY_REG_ID_WIDTH-1:0]  v_alloc_id,
  input  logic [COMMIT_NUM-1:0]                        v_commit_en,
  input  logic [COMMIT_NUM-1:0]                        v_release_en,
  input  logic [COMMIT_NUM*PHY_REG_ID_WIDTH-1:0]       v_release_id,
  input  logic                                         cancel_en,
  output logic [$clog2(FL_DEPTH):0]                    free_cnt
);

  localparam int unsigned IDX_W = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PHY_REG_ID_WIDTH-1:0] entry_q [FL_DEPTH];
  logic [PTR_W-1:0]            head_q, tail_q, chead_q;
  logic [PTR_W-1:0]            head_d, tail_d, chead_d;
  logic [PTR_W-1:0]            n_req, n_rel, n_cmt;
  logic [IDX_W-1:0]            rel_idx [COMMIT_NUM];
  logic                        alloc_fire;

  // Compacted allocate: each requesting slot takes the next entry after head.
  always_comb begin
    n_req      = '0;
    v_alloc_id = '0;
    for (int i = 0; i < INST_DECODE_NUM; i++) begin
      v_alloc_id[i*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] = entry_q[IDX_W'(head_q + n_req)];
      if (v_alloc_req[i]) n_req = n_req + PTR_W'(1);
    end
  end

  assign alloc_ready = !cancel_en && (free_cnt >= n_req);
  assign alloc_fire  = alloc_ready && (|v_alloc_req);

  // Release slots pack into consecutive entries starting at tail.
  always_comb begin
    n_rel = '0;
    for (int k = 0; k < COMMIT_NUM; k++) begin
      rel_idx[k] = IDX_W'(tail_q + n_rel);
      if (v_release_en[k]) n_rel = n_rel + PTR_W'(1);
    end
  end

  always_comb begin
    n_cmt = '0;
    for (int k = 0; k < COMMIT_NUM; k++) begin
      if (v_commit_en[k]) n_cmt = n_cmt + PTR_W'(1);
    end
  end

  // Next-state pointers; cancel rewinds head to the committed point including same-cycle commits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q + n_rel;
    chead_d = chead_q + n_cmt;
    if (cancel_en)       head_d = chead_d;
    else if (alloc_fire) head_d = head_q + n_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      chead_q  <= '0;
      tail_q   <= PTR_W'(FL_DEPTH);
      free_cnt <= PTR_W'(FL_DEPTH);
    end else begin
      head_q   <= head_d;
      chead_q  <= chead_d;
      tail_q   <= tail_d;
      free_cnt <= tail_d - head_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= PHY_REG_ID_WIDTH'(ARCH_ENTRY_NUM + i);
      end
    end else begin
      for (int k = 0; k < COMMIT_NUM; k++) begin
        if (v_release_en[k]) begin
          entry_q[rel_idx[k]] <= v_release_id[k*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_toy_rename_freelist.sv
// Randomized + directed bench for toy_rename_freelist against a queue-based free-list model.
module tb_toy_rename_freelist;

  logic        clk;
  logic        rst_n;
  logic [3:0]  v_alloc_req;
  logic        alloc_ready;
  logic [23:0] v_alloc_id;
  logic [3:0]  v_commit_en;
  logic [3:0]  v_release_en;
  logic [23:0] v_release_id;
  logic        cancel_en;
  logic [5:0]  free_cnt;

  int checks = 0;
  int errors = 0;

  // Model: fl holds allocatable IDs in order, spec holds allocated but uncommitted IDs.
  int fl[$];
  int spec[$];

  int obs_ready;
  int obs_free;
  int obs_id[4];

  toy_rename_freelist dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .v_alloc_req  (v_alloc_req),
    .alloc_ready  (alloc_ready),
    .v_alloc_id   (v_alloc_id),
    .v_commit_en  (v_commit_en),
    .v_release_en (v_release_en),
    .v_release_id (v_release_id),
    .cancel_en    (cancel_en),
    .free_cnt     (free_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pc(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic void model_reset();
    fl.delete();
    spec.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
  endfunction

  // One cycle: drive at negedge, check combinational and registered outputs, clock, update model.
  task automatic step(input logic [3:0] req, input logic [3:0] cmt, input logic [3:0] rel,
                      input logic [23:0] rel_ids, input logic cxl);
    int pre;
    bit exp_ready;
    v_alloc_req  = req;
    v_commit_en  = cmt;
    v_release_en = rel;
    v_release_id = rel_ids;
    cancel_en    = cxl;
    #1;
    obs_ready = int'(alloc_ready);
    obs_free  = int'(free_cnt);
    for (int i = 0; i < 4; i++) obs_id[i] = int'(v_alloc_id[i*6 +: 6]);
    check("free_cnt", obs_free, fl.size());
    exp_ready = !cxl && (fl.size() >= pc(req));
    check("alloc_ready", obs_ready, int'(exp_ready));
    pre = 0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (pre < fl.size()) check($sformatf("alloc_id%0d", i), obs_id[i], fl[pre]);
        pre++;
      end
    end
    @(posedge clk);
    if (exp_ready && req != 4'b0) begin
      for (int i = 0; i < pc(req); i++) spec.push_back(fl.pop_front());
    end
    for (int i = 0; i < pc(cmt); i++) void'(spec.pop_front());
    if (cxl) begin
      while (spec.size() > 0) fl.push_front(spec.pop_back());
    end
    for (int k = 0; k < 4; k++) if (rel[k]) fl.push_back(int'(rel_ids[k*6 +: 6]));
    @(negedge clk);
  endtask

  task automatic idle_reset();
    v_alloc_req = '0; v_commit_en = '0; v_release_en = '0; v_release_id = '0; cancel_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_free_cnt", int'(free_cnt), 32);
    check("rst_ready", int'(alloc_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Asynchronous reset asserted between edges while traffic is being driven.
  task automatic async_reset();
    v_alloc_req = 4'b1111; v_commit_en = 4'b0; v_release_en = 4'b0; cancel_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_free_cnt", int'(free_cnt), 32);
    check("arst_id0", int'(v_alloc_id[5:0]), 32);
    check("arst_id3", int'(v_alloc_id[23:18]), 35);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  rq, cm, rl;
    logic [23:0] ids;
    logic        cx;
    rst_n = 1'b0;
    v_alloc_req = '0; v_commit_en = '0; v_release_en = '0; v_release_id = '0; cancel_en = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_free_cnt", int'(free_cnt), 32);
    check("reset_ready", int'(alloc_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic allocate and compaction
    step(4'b1111, 4'b0, 4'b0, 24'd0, 1'b0);
    check("tp1_ready", obs_ready, 1);
    check("tp1_id0", obs_id[0], 32);
    check("tp1_id1", obs_id[1], 33);
    check("tp1_id2", obs_id[2], 34);
    check("tp1_id3", obs_id[3], 35);
    check("tp1_free", int'(free_cnt), 28);
    step(4'b1010, 4'b0, 4'b0, 24'd0, 1'b0);
    check("tp2_id1", obs_id[1], 36);
    check("tp2_id3", obs_id[3], 37);
    check("tp2_free", int'(free_cnt), 26);

    // Drain to 2 and test all-or-nothing
    repeat (6) step(4'b1111, 4'b0, 4'b0, 24'd0, 1'b0);
    check("drain_free", int'(free_cnt), 2);
    step(4'b0111, 4'b0, 4'b0, 24'd0, 1'b0);
    check("short_ready", obs_ready, 0);
    check("short_free", int'(free_cnt), 2);
    step(4'b0011, 4'b0, 4'b0, 24'd0, 1'b0);
    check("exact_ready", obs_ready, 1);
    check("empty_free", int'(free_cnt), 0);

    // Release with wrap; no same-cycle bypass
    step(4'b0000, 4'b1111, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5}, 1'b0);
    check("rel_same_free", obs_free, 0);
    check("rel_next_free", int'(free_cnt), 4);
    step(4'b1111, 4'b0, 4'b0, 24'd0, 1'b0);
    check("wrap_id0", obs_id[0], 5);
    check("wrap_id1", obs_id[1], 6);
    check("wrap_id2", obs_id[2], 7);
    check("wrap_id3", obs_id[3], 8);

    // Cancel rolls head back to commit_head
    idle_reset();
    step(4'b1111, 4'b0, 4'b0, 24'd0, 1'b0);
    step(4'b1111, 4'b0, 4'b0, 24'd0, 1'b0);
    step(4'b0000, 4'b0111, 4'b0, 24'd0, 1'b0);
    step(4'b0000, 4'b0, 4'b0, 24'd0, 1'b1);
    check("cxl_free", int'(free_cnt), 29);
    step(4'b0001, 4'b0, 4'b0, 24'd0, 1'b0);
    check("cxl_id0", obs_id[0], 35);

    // Cancel with same-cycle commits and a blocked request
    idle_reset();
    step(4'b1111, 4'b0, 4'b0, 24'd0, 1'b0);
    step(4'b1111, 4'b0, 4'b0, 24'd0, 1'b0);
    step(4'b0000, 4'b0111, 4'b0, 24'd0, 1'b0);
    step(4'b0001, 4'b0011, 4'b0, 24'd0, 1'b1);
    check("cxc_ready", obs_ready, 0);
    check("cxc_free", int'(free_cnt), 27);
    step(4'b0001, 4'b0, 4'b0, 24'd0, 1'b0);
    check("cxc_id0", obs_id[0], 37);
    step(4'b0110, 4'b0001, 4'b0, 24'd0, 1'b0);
    async_reset();

    // Randomized traffic honouring the overflow/underflow rules
    for (int c = 0; c < 3000; c++) begin
      rq = 4'($urandom);
      cx = ($urandom_range(0, 19) == 0);
      cm = 4'($urandom);
      while (pc(cm) > spec.size()) cm = cm & (cm - 4'd1);
      rl = 4'($urandom);
      while (fl.size() + spec.size() - pc(cm) + pc(rl) > 32) rl = rl & (rl - 4'd1);
      ids = 24'($urandom);
      step(rq, cm, rl, ids, cx);
      if (c % 997 == 996) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
